// File: rtl/byte_to_burst.sv
// byte_to_burst: packs strobed read bytes into 1/2/4/8-byte beat words; define BYTE_TO_BURST_ERR_EN for the strobe-gap timeout.
module byte_to_burst #(
    parameter int GAP_LIMIT = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [1:0]  burst_size,
    input  logic [3:0]  burst_num,
    input  logic        strobe,
    input  logic [7:0]  byte_in,
    output logic [63:0] pool_rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    state_t state, state_n;
    logic [1:0]  size_q;
    logic [3:0]  last_beat;
    logic [3:0]  beat;
    logic [2:0]  k;
    logic [2:0]  k_last;
    logic [63:0] asm_q, asm_n;
    logic        accept, cap, beat_end, last, timeout;

    if (GAP_LIMIT < 1) begin : g_bad_gap
        $error("GAP_LIMIT must be at least 1");
    end

    assign accept   = state == IDLE && start;
    assign cap      = state == COLLECT && strobe;
    assign k_last   = ~(3'b111 << size_q);
    assign beat_end = cap && k == k_last;
    assign last     = beat_end && beat == last_beat;
    assign busy     = state == COLLECT;

    always_comb begin
        asm_n = asm_q;
        asm_n[{k, 3'b000} +: 8] = byte_in;
    end

    always_comb begin
        state_n = state;
        if (accept) state_n = COLLECT;
        else if (last) state_n = DONE;
        else if (timeout) state_n = IDLE;
        else if (state == DONE) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else state <= state_n;
    end

    // Lanes above the beat width stay zero because the assembly word is cleared on every accepted start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            size_q      <= '0;
            last_beat   <= '0;
            beat        <= '0;
            k           <= '0;
            asm_q       <= '0;
            pool_rdata  <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            rdata_valid <= beat_end;
            done        <= last;
            if (accept) begin
                size_q    <= burst_size;
                last_beat <= (burst_num == 4'd0) ? 4'd0 : burst_num - 4'd1;
                beat      <= '0;
                k         <= '0;
                asm_q     <= '0;
            end else if (cap) begin
                asm_q <= asm_n;
                k     <= beat_end ? 3'd0 : k + 3'd1;
                if (beat_end) begin
                    beat       <= beat + 4'd1;
                    pool_rdata <= asm_n;
                end
            end
        end
    end

`ifdef BYTE_TO_BURST_ERR_EN
    localparam int GW = $clog2(GAP_LIMIT + 1);
    logic [GW-1:0] gap;

    assign timeout = state == COLLECT && !strobe && gap == GW'(GAP_LIMIT - 1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gap <= '0;
            err <= 1'b0;
        end else begin
            err <= timeout;
            gap <= (state != COLLECT || strobe || timeout) ? '0 : gap + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_byte_to_burst.sv
// tb_byte_to_burst: directed and randomized bursts checked against a byte-packing reference model.
module tb_byte_to_burst;
    logic        clk = 0, n_rst = 0, start = 0, strobe = 0;
    logic [1:0]  burst_size = 0;
    logic [3:0]  burst_num = 0;
    logic [7:0]  byte_in = 0;
    logic [63:0] pool_rdata;
    logic        rdata_valid, busy, done, err;
    int          checks = 0, errors = 0;
    logic [7:0]  data[$];
    int          gaps[$];

    always #5 clk = ~clk;

    byte_to_burst #(.GAP_LIMIT(4)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .burst_size(burst_size),
        .burst_num(burst_num), .strobe(strobe), .byte_in(byte_in),
        .pool_rdata(pool_rdata), .rdata_valid(rdata_valid), .busy(busy),
        .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Beat b is bytes [b*nb, b*nb+nb) packed little-endian, upper lanes zero.
    function automatic logic [63:0] beat_word(input int size, input int b);
        logic [63:0] w = '0;
        int nb = 1 << size;
        for (int i = 0; i < nb; i++) w[8*i +: 8] = data[b*nb + i];
        return w;
    endfunction

    task automatic run_burst(input int size, input int num, input bit strobe_at_start, input bit noise);
        int nb = 1 << size;
        int nbeats = (num == 0) ? 1 : num;
        start = 1; burst_size = 2'(size); burst_num = 4'(num);
        strobe = strobe_at_start; byte_in = 8'haa;
        step;
        start = 0; strobe = 0;
        chk("busy_after_start", busy, 1);
        for (int b = 0; b < nbeats; b++) begin
            for (int i = 0; i < nb; i++) begin
                int idx;
                idx = b*nb + i;
                for (int g = 0; g < gaps[idx]; g++) begin
                    strobe = 0;
                    if (noise) begin
                        start = 1'($urandom); burst_size = 2'($urandom); burst_num = 4'($urandom);
                    end
                    step;
                    chk("gap_no_valid", rdata_valid, 0);
                end
                strobe = 1; byte_in = data[idx];
                if (noise) begin
                    start = 1'($urandom); burst_size = 2'($urandom); burst_num = 4'($urandom);
                end
                step;
                if (i == nb - 1) begin
                    chk("beat_valid", rdata_valid, 1);
                    chk("beat_word", pool_rdata, beat_word(size, b));
                    chk("beat_done", done, b == nbeats - 1);
                end else begin
                    chk("mid_no_valid", rdata_valid, 0);
                end
            end
        end
        strobe = 0; start = noise;
        step;
        start = 0;
        chk("idle_busy", busy, 0);
        chk("done_clear", done, 0);
        chk("valid_clear", rdata_valid, 0);
        chk("hold_word", pool_rdata, beat_word(size, nbeats - 1));
        chk("no_err", err, 0);
    endtask

    task automatic zero_gaps(input int n);
        gaps.delete();
        for (int i = 0; i < n; i++) gaps.push_back(0);
    endtask

    initial begin
        step;
        chk("rst_rdata", pool_rdata, 0);
        chk("rst_valid", rdata_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        n_rst = 1;
        step;

        data = {8'h5a}; zero_gaps(1);
        run_burst(0, 1, 0, 0);
        data = {8'hf9, 8'he4}; zero_gaps(2);
        run_burst(1, 1, 0, 0);
        data = {8'h08, 8'h81, 8'h5f, 8'h48, 8'h2d, 8'h3d, 8'h43, 8'h62}; zero_gaps(8);
        run_burst(2, 2, 0, 0);
        data = {8'h6b, 8'h07, 8'h89, 8'hde, 8'ha4, 8'h74, 8'ha8, 8'h44};
        gaps = {0, 0, 0, 0, 2, 0, 0, 0};
        run_burst(3, 1, 0, 0);
        data = {8'h11, 8'h22}; zero_gaps(2);
        run_burst(1, 1, 1, 0);
        data = {8'hc1, 8'hc2, 8'hc3, 8'hc4}; zero_gaps(4);
        run_burst(2, 0, 0, 0);

        start = 1; burst_size = 2; burst_num = 1;
        step;
        start = 0;
        for (int i = 0; i < 3; i++) begin
            strobe = 1; byte_in = 8'(8'h70 + i);
            step;
        end
        strobe = 0;
        #2 n_rst = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", rdata_valid, 0);
        chk("arst_rdata", pool_rdata, 0);
        step;
        chk("arst_hold_valid", rdata_valid, 0);
        n_rst = 1;
        step;
        chk("post_rst_done", done, 0);
        data = {8'hde, 8'had, 8'hbe, 8'hef}; zero_gaps(4);
        run_burst(2, 1, 0, 0);

        start = 1; burst_size = 1; burst_num = 1;
        step;
        start = 0; strobe = 1; byte_in = 8'h34;
        step;
        strobe = 0;
        repeat (4) begin
            step;
            chk("gap_valid", rdata_valid, 0);
        end
`ifdef BYTE_TO_BURST_ERR_EN
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        step;
        chk("to_err_pulse", err, 0);
        chk("to_no_done", done, 0);
`else
        chk("gap_err", err, 0);
        chk("gap_busy", busy, 1);
        strobe = 1; byte_in = 8'h12;
        step;
        strobe = 0;
        chk("gap_valid_end", rdata_valid, 1);
        chk("gap_word", pool_rdata, 64'h1234);
        chk("gap_done", done, 1);
        step;
`endif

        repeat (25) begin
            int size, num, nb, nbeats;
            size = $urandom_range(0, 3);
            num = $urandom_range(0, 4);
            nb = 1 << size;
            nbeats = (num == 0) ? 1 : num;
            data.delete(); gaps.delete();
            for (int i = 0; i < nb*nbeats; i++) begin
                data.push_back(8'($urandom));
                gaps.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_burst(size, num, 1'($urandom), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
